if_stage: RTL and testbench
===========================

IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter IQ_DEPTH, default 4, instruction-queue entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h1ECEB000, first fetch address.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port imem_addr  output  32  fetch address, word aligned.
REQ-006 SHALL have port imem_rmask  output  4  4'hF for one cycle per request, else 0.
REQ-007 SHALL have port imem_rdata  input  32  instruction word, valid with imem_resp.
REQ-008 SHALL have port imem_resp  input  1  one-cycle response for the oldest outstanding request.
REQ-009 SHALL have port if_id_reg  output  if_id_t  queue head to decode {inst, pc, next_pc, order, valid}.
REQ-010 SHALL have port rob_stall, rs_stall  input  1 each  backend cannot accept the head.
REQ-011 SHALL have port jump, stall  input  1 each  decode redirect and hold request.
REQ-012 SHALL have port jal_pc  input  32  decode redirect target.
REQ-013 SHALL have port flush  input  1  backend mispredict or jalr resolve.
REQ-014 SHALL have port flush_pc  input  32  backend redirect target.

Function
REQ-015 SHALL keep at most one imem request outstanding.
REQ-016 SHALL use FSM states REQ (may issue), WAIT (request live), DROP (outstanding response stale), HALT (no issue).
REQ-017 In REQ, SHALL issue imem_addr=pc, imem_rmask=4'hF when queue count<IQ_DEPTH, then go to WAIT.
REQ-018 In WAIT on imem_resp, SHALL enqueue {imem_rdata, fetch pc}, set pc=pc+4, and issue the next request the same cycle if post-enqueue count<IQ_DEPTH (stay WAIT), else go to REQ.
REQ-019 SHALL present the head on if_id_reg with valid=1 when non-empty, next_pc=pc+4, order=order counter; valid=0 and other fields 0 when empty.
REQ-020 SHALL dequeue the head when valid && !rob_stall && !rs_stall and increment the 64-bit order counter on each dequeue only.
REQ-021 On jump && !stall with dequeue, SHALL discard all non-head entries and set pc=jal_pc; an outstanding request goes to DROP, otherwise REQ.
REQ-022 On jump && stall (jalr) with dequeue, SHALL discard all non-head entries and enter HALT; an outstanding response in HALT is discarded.
REQ-023 jump or stall without dequeue SHALL change nothing (decode re-asserts next cycle).
REQ-024 On flush, SHALL empty the queue, suppress the dequeue, set pc=flush_pc, go to DROP if a response is outstanding, else REQ; flush overrides jump, stall and imem_resp enqueue in the same cycle.
REQ-025 In DROP, imem_resp SHALL be ignored (no enqueue) and the state goes to REQ.
REQ-026 HALT SHALL persist until flush.
REQ-027 Enqueue and dequeue in the same cycle SHALL keep count unchanged; pointers SHALL wrap modulo IQ_DEPTH.

Reset
REQ-028 On rst, SHALL immediately set pc=RESET_PC, state=REQ, queue empty, order=0, imem_rmask=0, imem_addr=0, if_id_reg all zero.
REQ-029 A response arriving in the first cycle after rst deassertion SHALL be ignored, because no request is outstanding.

Structure
REQ-030 SHALL take if_id_t from rv32i_types; SHALL add an if_state_t enum {REQ, WAIT, DROP, HALT} to that package.
REQ-031 SHALL instantiate one sub-module, inst_queue (parameterised circular FIFO with flush, keep-head-only and count outputs).

Verification
REQ-032 After reset, imem returns 0x00000013 after 1 cycle -> first request at 0x1ECEB000; if_id_reg.pc=0x1ECEB000, order=0.
REQ-033 Hold rob_stall=1 for 20 cycles -> exactly 4 entries queued, no request issued while full; release -> orders 0..3 in pc order.
REQ-034 Head jal with jal_pc=0x1ECEB100 while a request is outstanding -> stale response dropped; next enqueued pc=0x1ECEB100.
REQ-035 Head jalr (jump=1, stall=1) -> HALT, rmask stays 0; flush with flush_pc=0x1ECEB200 -> fetch resumes at 0x1ECEB200.
REQ-036 flush and imem_resp in the same cycle -> queue empty, response not enqueued, next request at flush_pc.
REQ-037 Assert rst while in WAIT -> outputs zero at once; after release, fetch restarts at RESET_PC, order=0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: fetch/decode register layout, fetch FSM
// states and the instruction-queue entry format.
package rv32i_types;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic [63:0] order;
        logic        valid;
    } if_id_t;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2,
        HALT = 2'd3
    } if_state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } iq_entry_t;

    localparam logic [3:0] RMASK_WORD = 4'hF;

    // Sequential fetch successor.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_inst_queue.sv
// Circular instruction FIFO. flush empties it; keep_head discards every
// entry behind the head (and the head too when it is dequeued that cycle).
module inst_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    keep_head,
    input  logic                    enq,
    input  iq_entry_t               enq_data,
    input  logic                    deq,
    output iq_entry_t               head,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    iq_entry_t         mem_r [DEPTH];
    logic [PW-1:0]     head_r;
    logic [PW-1:0]     tail_r;
    logic [CW-1:0]     count_r;
    logic              enq_ok_s;
    logic              deq_ok_s;

    assign enq_ok_s = enq && !flush && !keep_head && (count_r < DEPTH_C);
    assign deq_ok_s = deq && !flush && (count_r != {CW{1'b0}});
    assign head     = mem_r[head_r];
    assign count    = count_r;

    // Entry storage: written only on an accepted enqueue, so no reset needed.
    always_ff @(posedge clk) begin
        if (enq_ok_s) begin
            mem_r[tail_r] <= enq_data;
        end
    end

    // Head/tail pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (flush) begin
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (keep_head) begin
            if (deq_ok_s) begin
                head_r  <= head_r + PW'(1);
                tail_r  <= head_r + PW'(1);
                count_r <= {CW{1'b0}};
            end else if (count_r != {CW{1'b0}}) begin
                tail_r  <= head_r + PW'(1);
                count_r <= CW'(1);
            end else begin
                tail_r  <= head_r;
                count_r <= {CW{1'b0}};
            end
        end else begin
            if (enq_ok_s) begin
                tail_r <= tail_r + PW'(1);
            end
            if (deq_ok_s) begin
                head_r <= head_r + PW'(1);
            end
            count_r <= count_r + (enq_ok_s ? CW'(1) : CW'(0)) - (deq_ok_s ? CW'(1) : CW'(0));
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding imem requests, instruction
// queue to decode, decode redirect (jal), jalr halt and backend flush.
module if_stage
    import rv32i_types::*;
#(
    parameter int          IQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h1ECEB000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic [3:0]  imem_rmask,
    input  logic [31:0] imem_rdata,
    input  logic        imem_resp,
    output if_id_t      if_id_reg,
    input  logic        rob_stall,
    input  logic        rs_stall,
    input  logic        jump,
    input  logic        stall,
    input  logic [31:0] jal_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc
);

    localparam int CW = $clog2(IQ_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);

    if_state_t     state_r, state_next_s;
    logic [31:0]   pc_r, pc_next_s;
    logic [63:0]   order_r;
    logic          outstanding_r;
    logic [3:0]    rmask_r;
    logic [31:0]   addr_r;

    logic          issue_s;
    logic [31:0]   issue_addr_s;
    logic          enq_s;
    logic          keep_head_s;
    logic          q_flush_s;
    logic          deq_s;
    logic [CW-1:0] count_s;
    logic [CW-1:0] count_after_s;
    iq_entry_t     head_s;
    iq_entry_t     enq_data_s;
    if_id_t        if_id_s;

    assign deq_s         = (count_s != {CW{1'b0}}) && !rob_stall && !rs_stall && !flush;
    assign count_after_s = count_s + CW'(1) - (deq_s ? CW'(1) : CW'(0));
    assign enq_data_s    = '{inst: imem_rdata, pc: pc_r};
    assign imem_addr     = addr_r;
    assign imem_rmask    = rmask_r;
    assign if_id_reg     = if_id_s;

    inst_queue #(.DEPTH(IQ_DEPTH)) u_inst_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (q_flush_s),
        .keep_head (keep_head_s),
        .enq       (enq_s),
        .enq_data  (enq_data_s),
        .deq       (deq_s),
        .head      (head_s),
        .count     (count_s)
    );

    // Fetch FSM next state: redirects take priority over normal issue/enqueue.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        issue_s      = 1'b0;
        issue_addr_s = pc_r;
        enq_s        = 1'b0;
        keep_head_s  = 1'b0;
        q_flush_s    = 1'b0;
        if (flush) begin
            q_flush_s    = 1'b1;
            pc_next_s    = flush_pc;
            state_next_s = (outstanding_r && !imem_resp) ? DROP : REQ;
        end else if (jump && !stall && deq_s) begin
            keep_head_s  = 1'b1;
            pc_next_s    = jal_pc;
            state_next_s = (outstanding_r && !imem_resp) ? DROP : REQ;
        end else if (jump && stall && deq_s) begin
            keep_head_s  = 1'b1;
            state_next_s = HALT;
        end else begin
            case (state_r)
                REQ: begin
                    if (count_s < DEPTH_C) begin
                        issue_s      = 1'b1;
                        state_next_s = WAIT;
                    end else begin
                        state_next_s = REQ;
                    end
                end
                WAIT: begin
                    if (imem_resp) begin
                        enq_s        = 1'b1;
                        pc_next_s    = pc_plus4(pc_r);
                        issue_addr_s = pc_plus4(pc_r);
                        if (count_after_s < DEPTH_C) begin
                            issue_s      = 1'b1;
                            state_next_s = WAIT;
                        end else begin
                            state_next_s = REQ;
                        end
                    end else begin
                        state_next_s = WAIT;
                    end
                end
                DROP: begin
                    if (imem_resp) begin
                        state_next_s = REQ;
                    end else begin
                        state_next_s = DROP;
                    end
                end
                HALT: begin
                    state_next_s = HALT;
                end
                default: begin
                    state_next_s = REQ;
                end
            endcase
        end
    end

    // Head of queue to decode; all-zero when the queue is empty.
    always_comb begin
        if_id_s = '0;
        if (count_s != {CW{1'b0}}) begin
            if_id_s.inst    = head_s.inst;
            if_id_s.pc      = head_s.pc;
            if_id_s.next_pc = pc_plus4(head_s.pc);
            if_id_s.order   = order_r;
            if_id_s.valid   = 1'b1;
        end else begin
            if_id_s.valid   = 1'b0;
        end
    end

    // State, pc, order counter, outstanding tracker and registered imem request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= REQ;
            pc_r          <= RESET_PC;
            order_r       <= 64'd0;
            outstanding_r <= 1'b0;
            rmask_r       <= 4'h0;
            addr_r        <= 32'd0;
        end else begin
            state_r       <= state_next_s;
            pc_r          <= pc_next_s;
            order_r       <= order_r + (deq_s ? 64'd1 : 64'd0);
            outstanding_r <= issue_s ? 1'b1 : (imem_resp ? 1'b0 : outstanding_r);
            rmask_r       <= issue_s ? RMASK_WORD : 4'h0;
            addr_r        <= issue_s ? issue_addr_s : addr_r;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a one-cycle-latency imem model driven from the
// stimulus process, dequeue log, and hand-computed expectations.
module tb_if_stage;
    import rv32i_types::*;

    localparam logic [31:0] RP = 32'h1ECEB000;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    if_id_t      if_id_reg;
    logic        rob_stall, rs_stall, jump, stall, flush;
    logic [31:0] jal_pc, flush_pc;

    int          checks = 0;
    int          failures = 0;
    int          req_cnt = 0;
    int          req0;
    int          n;
    logic        mem_pend = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] deq_pc [$];
    logic [63:0] deq_ord [$];

    if_stage #(.IQ_DEPTH(4), .RESET_PC(RP)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .if_id_reg  (if_id_reg),
        .rob_stall  (rob_stall),
        .rs_stall   (rs_stall),
        .jump       (jump),
        .stall      (stall),
        .jal_pc     (jal_pc),
        .flush      (flush),
        .flush_pc   (flush_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h00000013 | ((a - RP) << 8);
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: log the dequeue about to happen, then play the imem model.
    task automatic tick();
        if (!rst && if_id_reg.valid && !rob_stall && !rs_stall && !flush) begin
            deq_pc.push_back(if_id_reg.pc);
            deq_ord.push_back(if_id_reg.order);
        end
        @(posedge clk);
        #1;
        imem_resp = 1'b0;
        if (rst) begin
            mem_pend = 1'b0;
        end else begin
            if (mem_pend) begin
                imem_resp  = 1'b1;
                imem_rdata = mem_word(mem_addr);
                mem_pend   = 1'b0;
            end
            if (imem_rmask == 4'hF) begin
                mem_pend = 1'b1;
                mem_addr = imem_addr;
                req_cnt++;
            end
        end
    endtask

    task automatic wait_valid(input string tag);
        int k = 0;
        while (!if_id_reg.valid && k < 30) begin
            tick();
            k++;
        end
        check_eq(tag, {63'd0, if_id_reg.valid}, 64'd1);
    endtask

    task automatic wait_head_and_req(input string tag);
        int k = 0;
        while (!(if_id_reg.valid && imem_rmask == 4'hF) && k < 30) begin
            tick();
            k++;
        end
        check_eq(tag, {63'd0, if_id_reg.valid && imem_rmask == 4'hF}, 64'd1);
    endtask

    initial begin
        rst = 1'b1; imem_rdata = 32'd0; imem_resp = 1'b0;
        rob_stall = 1'b1; rs_stall = 1'b0; jump = 1'b0; stall = 1'b0;
        flush = 1'b0; jal_pc = 32'd0; flush_pc = 32'd0;
        tick(); tick();
        check_eq("rst_rmask", {60'd0, imem_rmask}, 64'd0);
        check_eq("rst_addr", {32'd0, imem_addr}, 64'd0);
        check_eq("rst_valid", {63'd0, if_id_reg.valid}, 64'd0);
        check_eq("rst_pc", {32'd0, if_id_reg.pc}, 64'd0);
        check_eq("rst_order", if_id_reg.order, 64'd0);

        // Release with a spurious response in the first cycle: must be ignored.
        rst = 1'b0;
        imem_resp = 1'b1; imem_rdata = 32'hDEADBEEF;
        tick();
        check_eq("first_rmask", {60'd0, imem_rmask}, 64'hF);
        check_eq("first_addr", {32'd0, imem_addr}, {32'd0, RP});
        check_eq("spurious_valid", {63'd0, if_id_reg.valid}, 64'd0);
        tick(); tick();
        check_eq("first_valid", {63'd0, if_id_reg.valid}, 64'd1);
        check_eq("first_pc", {32'd0, if_id_reg.pc}, {32'd0, RP});
        check_eq("first_inst", {32'd0, if_id_reg.inst}, 64'h13);
        check_eq("first_next_pc", {32'd0, if_id_reg.next_pc}, {32'd0, RP + 32'd4});
        check_eq("first_order", if_id_reg.order, 64'd0);

        // Backend stalled: the queue fills to 4 and fetch stops.
        for (int i = 0; i < 17; i++) tick();
        check_eq("full_reqs", req_cnt, 64'd4);
        check_eq("full_rmask", {60'd0, imem_rmask}, 64'd0);
        check_eq("full_head_pc", {32'd0, if_id_reg.pc}, {32'd0, RP});
        rob_stall = 1'b0;
        n = 0;
        while (deq_pc.size() < 4 && n < 30) begin
            tick();
            n++;
        end
        check_eq("drain_count", deq_pc.size(), 64'd4);
        for (int i = 0; i < 4 && i < deq_pc.size(); i++) begin
            check_eq("drain_pc", {32'd0, deq_pc[i]}, {32'd0, RP + 32'(4 * i)});
            check_eq("drain_order", deq_ord[i], 64'(i));
        end

        // jal at the head with a request in flight: stale response dropped.
        wait_head_and_req("jal_setup");
        jump = 1'b1; stall = 1'b0; jal_pc = 32'h1ECEB100;
        tick();
        jump = 1'b0;
        check_eq("jal_rmask", {60'd0, imem_rmask}, 64'd0);
        check_eq("jal_valid", {63'd0, if_id_reg.valid}, 64'd0);
        tick();
        check_eq("stale_valid", {63'd0, if_id_reg.valid}, 64'd0);
        tick();
        check_eq("jal_req_rmask", {60'd0, imem_rmask}, 64'hF);
        check_eq("jal_req_addr", {32'd0, imem_addr}, 64'h1ECEB100);
        wait_valid("jal_wait");
        check_eq("jal_pc", {32'd0, if_id_reg.pc}, 64'h1ECEB100);
        check_eq("jal_inst", {32'd0, if_id_reg.inst}, 64'h00010013);
        check_eq("jal_order", if_id_reg.order, 64'(deq_pc.size()));

        // jalr at the head: halt until flush.
        wait_head_and_req("jalr_setup");
        jump = 1'b1; stall = 1'b1;
        req0 = req_cnt;
        tick();
        jump = 1'b0; stall = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check_eq("halt_reqs", req_cnt, 64'(req0));
        check_eq("halt_valid", {63'd0, if_id_reg.valid}, 64'd0);
        flush = 1'b1; flush_pc = 32'h1ECEB200;
        tick();
        flush = 1'b0;
        tick();
        check_eq("resume_rmask", {60'd0, imem_rmask}, 64'hF);
        check_eq("resume_addr", {32'd0, imem_addr}, 64'h1ECEB200);
        wait_valid("resume_wait");
        check_eq("resume_pc", {32'd0, if_id_reg.pc}, 64'h1ECEB200);
        check_eq("resume_inst", {32'd0, if_id_reg.inst}, 64'h00020013);

        // flush coinciding with a response, queue non-empty.
        rs_stall = 1'b1;
        n = 0;
        while (!(imem_resp && if_id_reg.valid) && n < 30) begin
            tick();
            n++;
        end
        check_eq("fr_setup", {63'd0, imem_resp && if_id_reg.valid}, 64'd1);
        flush = 1'b1; flush_pc = 32'h1ECEB300;
        tick();
        flush = 1'b0;
        check_eq("fr_valid", {63'd0, if_id_reg.valid}, 64'd0);
        check_eq("fr_rmask0", {60'd0, imem_rmask}, 64'd0);
        tick();
        check_eq("fr_rmask", {60'd0, imem_rmask}, 64'hF);
        check_eq("fr_addr", {32'd0, imem_addr}, 64'h1ECEB300);
        rs_stall = 1'b0;
        wait_valid("fr_wait");
        check_eq("fr_pc", {32'd0, if_id_reg.pc}, 64'h1ECEB300);

        // Reset while a request is outstanding.
        n = 0;
        while (imem_rmask != 4'hF && n < 30) begin
            tick();
            n++;
        end
        check_eq("wrst_setup", {60'd0, imem_rmask}, 64'hF);
        rst = 1'b1;
        #1;
        check_eq("wrst_rmask", {60'd0, imem_rmask}, 64'd0);
        check_eq("wrst_addr", {32'd0, imem_addr}, 64'd0);
        check_eq("wrst_valid", {63'd0, if_id_reg.valid}, 64'd0);
        check_eq("wrst_order", if_id_reg.order, 64'd0);
        tick(); tick();
        rst = 1'b0;
        deq_pc.delete();
        deq_ord.delete();
        tick();
        check_eq("wrst_req_rmask", {60'd0, imem_rmask}, 64'hF);
        check_eq("wrst_req_addr", {32'd0, imem_addr}, {32'd0, RP});
        wait_valid("wrst_wait");
        check_eq("wrst_pc", {32'd0, if_id_reg.pc}, {32'd0, RP});
        check_eq("wrst_first_order", if_id_reg.order, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
